tlk2711_link_test_ctrl: RTL and testbench
=========================================

Name: tlk2711_link_test_ctrl

Overview:
- Sequences TLK2711 RX link test-mode.
- Drives the rx validation checker's soft reset and check enable, then judges the checker's error pulses over frame windows.
- Declares the link up, retries training, or declares failure.
- Sits between the rx validation checker and the PS register bank in the TLK2711 RX clock domain.

Parameters:
RST_CYCLES, 16, width of the o_soft_rst pulse in cycles
SETTLE_CYCLES, 1024, cycles after reset before errors are counted (checker acquires sync)
WINDOW_FRAMES, 256, frames per judgement window
ERR_THRESH, 4, errors within one window that force a retry
FRAME_TIMEOUT, 65536, max cycles between i_frame_done pulses in CHECK/LINKED
MAX_RETRY, 8, retries before FAIL
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  RX recovered clock
rst_n  in  1  async active-low reset
i_start  in  1  pulse; begin test from IDLE or FAIL
i_stop  in  1  pulse; abort to IDLE from any state
i_2711_los  in  1  loss-of-signal, already synchronised, 1 = no signal
i_check_error  in  1  checker error pulse
i_error_status  in  4  checker error code, valid with i_check_error
i_frame_done  in  1  one pulse per received frame (EOF)
o_soft_rst  out  1  checker soft reset
o_check_ena  out  1  checker enable
o_link_up  out  1  link qualified
o_fail  out  1  retries exhausted
o_state  out  3  current FSM state
o_err_cnt  out  CNT_W  total counted errors, saturating
o_frame_cnt  out  CNT_W  total counted frames, saturating
o_last_err_status  out  4  status latched at the last counted error
o_retry_cnt  out  8  retries since start

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE.
- All outputs are registered; o_state reflects the current state.
- States (encoding 0..6): IDLE, RESET, SETTLE, CHECK, LINKED, RETRY, FAIL.
- IDLE: soft_rst=0, check_ena=0. On i_start: clear all counters and retry_cnt, go to RESET.
- RESET: soft_rst=1 for exactly RST_CYCLES cycles, check_ena=0, then go to SETTLE.
- SETTLE: check_ena=1, soft_rst=0; errors and frames ignored.
  - i_2711_los goes to RETRY.
  - After SETTLE_CYCLES cycles, go to CHECK with window frame/error counters cleared.
- CHECK: count frames and errors.
  - Go to RETRY if (window_err + this cycle's error) >= ERR_THRESH, or LOS, or timeout.
  - Otherwise, when window_frames + this cycle's frame reaches WINDOW_FRAMES, go to LINKED; window counters clear.
  - Retry wins when a window end and the threshold crossing occur in the same cycle.
- LINKED: o_link_up=1. Same counting and RETRY conditions as CHECK; window counters restart every WINDOW_FRAMES frames.
- Timeout: a cycle counter clears on each i_frame_done and on entry to CHECK. Reaching FRAME_TIMEOUT counts as a timeout.
- RETRY (1 cycle): check_ena=0, link_up=0, retry_cnt++ (saturating). If the new value equals MAX_RETRY, go to FAIL; else go to RESET.
- FAIL: o_fail=1, check_ena=0. i_start restarts exactly as from IDLE.
- i_stop: from any state, IDLE next cycle; highest priority, wins over a simultaneous i_start. Counters are held, not cleared.
- Counting:
  - o_err_cnt and o_frame_cnt increment only in CHECK/LINKED and saturate at all-ones.
  - An error and a frame in the same cycle are both counted.
  - o_last_err_status updates on every counted error.
- Window counters are internal, sized clog2(WINDOW_FRAMES+1) and clog2(ERR_THRESH+1).
- Reset mid-operation: asynchronous return to reset values; soft_rst drops immediately.

Decomposition:
- Shared package tlk2711_pkg holds:
  - link_state_t encoding;
  - K-code and frame-header constants (K28_5, D5_6, K27_7, K28_2, K30_7, K29_7, 16'hEB90, 16'hE116), shared with the checker;
  - error status code constants 1..10.
- One sub-module: tlk2711_sat_cnt (parameterised width, clear, increment, saturating), used for err/frame/retry counters.

Test Plan:
- Clean link: i_start, frame_done every 500 cycles, no errors -> soft_rst high exactly 16 cycles; CHECK after 1024 settle cycles; LINKED after 256 frames; o_frame_cnt=256 at entry.
- Errors during SETTLE: 10 error pulses with status 1 -> o_err_cnt stays 0; no retry.
- Bad window: 4 errors (status 8) within the first 100 frames of CHECK -> RETRY; o_retry_cnt=1; a second 16-cycle soft_rst pulse; o_last_err_status=8.
- Persistent failure: an error every frame -> after 8 retries o_fail=1, o_state=FAIL, check_ena=0. Then i_start -> counters cleared, RESET.
- LOS/timeout in LINKED: raise i_2711_los -> link_up drops the next cycle, RETRY. Separately, stop frame_done for 65536 cycles -> RETRY.
- Priority: i_start and i_stop in the same cycle in FAIL -> IDLE. Error and frame_done in the same cycle -> both counters +1. rst_n low mid-CHECK -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// ---------------------------------------------------------------------------
// tlk2711_pkg
// Shared definitions for the TLK2711 RX path: link test controller state
// encoding, K-code and frame-header constants used by the rx validation
// checker, and the checker's error status codes.
// ---------------------------------------------------------------------------
package tlk2711_pkg;

    // Link test controller states; the numeric values are visible on o_state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LINKED = 3'd4,
        ST_RETRY  = 3'd5,
        ST_FAIL   = 3'd6
    } link_state_t;

    // 8b/10b control characters
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] K29_7 = 8'hFD;

    // Frame header words
    localparam logic [15:0] FRAME_HDR_0 = 16'hEB90;
    localparam logic [15:0] FRAME_HDR_1 = 16'hE116;

    // Checker error status codes (valid with i_check_error)
    localparam logic [3:0] ERR_HDR_MISMATCH = 4'd1;
    localparam logic [3:0] ERR_K_CODE       = 4'd2;
    localparam logic [3:0] ERR_DISPARITY    = 4'd3;
    localparam logic [3:0] ERR_LEN_SHORT    = 4'd4;
    localparam logic [3:0] ERR_LEN_LONG     = 4'd5;
    localparam logic [3:0] ERR_SEQ          = 4'd6;
    localparam logic [3:0] ERR_CRC          = 4'd7;
    localparam logic [3:0] ERR_DATA         = 4'd8;
    localparam logic [3:0] ERR_EOF_MISSING  = 4'd9;
    localparam logic [3:0] ERR_SYNC_LOST    = 4'd10;

    // States in which the checker's frames and errors are judged.
    function automatic logic is_check_state(input link_state_t s);
        return (s == ST_CHECK) || (s == ST_LINKED);
    endfunction

endpackage

// File: rtl/tlk2711_sat_cnt.sv
// ---------------------------------------------------------------------------
// tlk2711_sat_cnt
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero
//   inc        : increment by one, holding at all-ones
//   cnt        : counter value
// ---------------------------------------------------------------------------
module tlk2711_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tlk2711_link_test_ctrl.sv
// ---------------------------------------------------------------------------
// tlk2711_link_test_ctrl
// Sequences TLK2711 RX link test mode: pulses the rx checker's soft reset,
// lets it acquire sync, then judges its error pulses over windows of frames.
// Declares link up, retries training, or gives up after MAX_RETRY retries.
//   clk, rst_n        : RX recovered clock, async active-low reset
//   i_start / i_stop  : start (from IDLE/FAIL) / abort-to-IDLE pulses
//   i_2711_los        : synchronised loss of signal
//   i_check_error     : checker error pulse, i_error_status its code
//   i_frame_done      : one pulse per received frame
//   o_soft_rst        : checker soft reset
//   o_check_ena       : checker enable
//   o_link_up, o_fail : link qualified / retries exhausted
//   o_state           : current state (link_state_t encoding)
//   o_err_cnt, o_frame_cnt, o_last_err_status, o_retry_cnt : statistics
// ---------------------------------------------------------------------------
module tlk2711_link_test_ctrl
    import tlk2711_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned WINDOW_FRAMES = 256,
    parameter int unsigned ERR_THRESH    = 4,
    parameter int unsigned FRAME_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY     = 8,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_2711_los,
    input  logic             i_check_error,
    input  logic [3:0]       i_error_status,
    input  logic             i_frame_done,
    output logic             o_soft_rst,
    output logic             o_check_ena,
    output logic             o_link_up,
    output logic             o_fail,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [3:0]       o_last_err_status,
    output logic [7:0]       o_retry_cnt
);

    localparam int unsigned PH_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
    localparam int unsigned FW     = $clog2(WINDOW_FRAMES + 1);
    localparam int unsigned EW     = $clog2(ERR_THRESH + 1);
    localparam int unsigned TW     = $clog2(FRAME_TIMEOUT + 1);

    localparam int unsigned RST_LAST_I    = RST_CYCLES - 1;
    localparam int unsigned SETTLE_LAST_I = SETTLE_CYCLES - 1;

    localparam logic [PH_W-1:0] RST_LAST    = RST_LAST_I[PH_W-1:0];
    localparam logic [PH_W-1:0] SETTLE_LAST = SETTLE_LAST_I[PH_W-1:0];
    localparam logic [FW:0]     WIN_LIM     = WINDOW_FRAMES[FW:0];
    localparam logic [EW:0]     ERR_LIM     = ERR_THRESH[EW:0];
    localparam logic [TW-1:0]   TO_LIM      = FRAME_TIMEOUT[TW-1:0];
    localparam logic [7:0]      RETRY_LIM   = MAX_RETRY[7:0];

    link_state_t     state;
    link_state_t     state_nxt;
    logic [PH_W-1:0] phase_cnt;
    logic [FW-1:0]   win_frm;
    logic [EW-1:0]   win_err;
    logic [TW-1:0]   to_cnt;
    logic [FW:0]     win_frm_sum;
    logic [EW:0]     win_err_sum;
    logic [7:0]      retry_inc;

    logic in_chk;
    logic counting;
    logic start_clr;
    logic frame_tout;
    logic win_end;
    logic retry_req;
    logic chk_entry;

    assign in_chk      = is_check_state(state);
    assign counting    = in_chk && !i_stop;
    assign start_clr   = !i_stop && i_start && ((state == ST_IDLE) || (state == ST_FAIL));
    assign win_frm_sum = {1'b0, win_frm} + {{FW{1'b0}}, i_frame_done};
    assign win_err_sum = {1'b0, win_err} + {{EW{1'b0}}, i_check_error};
    assign frame_tout  = (to_cnt == TO_LIM);
    assign win_end     = (win_frm_sum == WIN_LIM);
    assign retry_req   = (win_err_sum >= ERR_LIM) || i_2711_los || frame_tout;
    assign retry_inc   = (o_retry_cnt == 8'hFF) ? 8'hFF : o_retry_cnt + 8'd1;
    assign chk_entry   = (state == ST_SETTLE) && (state_nxt == ST_CHECK);

    assign o_state = state;

    // Next-state decode; i_stop overrides everything.
    always_comb begin
        state_nxt = state;
        if (i_stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_FAIL: if (i_start) state_nxt = ST_RESET;
                ST_RESET:         if (phase_cnt == RST_LAST) state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (i_2711_los)                    state_nxt = ST_RETRY;
                    else if (phase_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
                end
                // Retry takes precedence over a window completing this cycle.
                ST_CHECK, ST_LINKED: begin
                    if (retry_req)    state_nxt = ST_RETRY;
                    else if (win_end) state_nxt = ST_LINKED;
                end
                ST_RETRY: state_nxt = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_RESET;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with outputs registered from the next state, so each
    // output lines up with o_state on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            o_soft_rst  <= 1'b0;
            o_check_ena <= 1'b0;
            o_link_up   <= 1'b0;
            o_fail      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_soft_rst  <= (state_nxt == ST_RESET);
            o_check_ena <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK) ||
                           (state_nxt == ST_LINKED);
            o_link_up   <= (state_nxt == ST_LINKED);
            o_fail      <= (state_nxt == ST_FAIL);
        end
    end

    // Phase timer for RESET/SETTLE: restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state_nxt != state) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
        end
    end

    // Window accumulators and frame timeout. Both accumulators stay below
    // their limits because reaching a limit either ends the window or retries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_frm <= '0;
            win_err <= '0;
            to_cnt  <= '0;
        end else if (chk_entry) begin
            win_frm <= '0;
            win_err <= '0;
            to_cnt  <= '0;
        end else if (counting) begin
            if (win_end) begin
                win_frm <= '0;
                win_err <= '0;
            end else begin
                win_frm <= win_frm_sum[FW-1:0];
                win_err <= win_err_sum[EW-1:0];
            end
            if (i_frame_done) begin
                to_cnt <= '0;
            end else if (!frame_tout) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_last_err_status <= '0;
        end else if (start_clr) begin
            o_last_err_status <= '0;
        end else if (counting && i_check_error) begin
            o_last_err_status <= i_error_status;
        end
    end

    tlk2711_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_clr),
        .inc   (counting && i_check_error),
        .cnt   (o_err_cnt)
    );

    tlk2711_sat_cnt #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_clr),
        .inc   (counting && i_frame_done),
        .cnt   (o_frame_cnt)
    );

    tlk2711_sat_cnt #(.W(8)) u_retry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_clr),
        .inc   ((state == ST_RETRY) && !i_stop),
        .cnt   (o_retry_cnt)
    );

endmodule

// File: tb/tb_tlk2711_link_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlk2711_link_test_ctrl
// Self-checking bench for tlk2711_link_test_ctrl with shortened timing
// parameters. A behavioural model of the link test sequence predicts every
// output each cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_tlk2711_link_test_ctrl;

    localparam int TB_RST    = 16;
    localparam int TB_SETTLE = 64;
    localparam int TB_WIN    = 8;
    localparam int TB_THR    = 4;
    localparam int TB_TO     = 200;
    localparam int TB_MAXR   = 8;
    localparam int TB_CW     = 6;
    localparam int CMAX      = (1 << TB_CW) - 1;
    localparam int FD_LO     = 2;
    localparam int FD_HI     = 10;

    localparam int S_IDLE = 0, S_RESET = 1, S_SETTLE = 2, S_CHECK = 3,
                   S_LINKED = 4, S_RETRY = 5, S_FAIL = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_stop = 1'b0;
    logic             i_2711_los = 1'b0;
    logic             i_check_error = 1'b0;
    logic [3:0]       i_error_status = 4'd0;
    logic             i_frame_done = 1'b0;
    logic             o_soft_rst;
    logic             o_check_ena;
    logic             o_link_up;
    logic             o_fail;
    logic [2:0]       o_state;
    logic [TB_CW-1:0] o_err_cnt;
    logic [TB_CW-1:0] o_frame_cnt;
    logic [3:0]       o_last_err_status;
    logic [7:0]       o_retry_cnt;

    tlk2711_link_test_ctrl #(
        .RST_CYCLES    (TB_RST),
        .SETTLE_CYCLES (TB_SETTLE),
        .WINDOW_FRAMES (TB_WIN),
        .ERR_THRESH    (TB_THR),
        .FRAME_TIMEOUT (TB_TO),
        .MAX_RETRY     (TB_MAXR),
        .CNT_W         (TB_CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_stop            (i_stop),
        .i_2711_los        (i_2711_los),
        .i_check_error     (i_check_error),
        .i_error_status    (i_error_status),
        .i_frame_done      (i_frame_done),
        .o_soft_rst        (o_soft_rst),
        .o_check_ena       (o_check_ena),
        .o_link_up         (o_link_up),
        .o_fail            (o_fail),
        .o_state           (o_state),
        .o_err_cnt         (o_err_cnt),
        .o_frame_cnt       (o_frame_cnt),
        .o_last_err_status (o_last_err_status),
        .o_retry_cnt       (o_retry_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Behavioural model: phase with remaining-cycle countdown, window tallies,
    // cycles since the last frame, and the statistics.
    int m_state = S_IDLE;
    int m_left  = 0;
    int m_wf = 0, m_we = 0, m_since = 0;
    int m_err = 0, m_frm = 0, m_last = 0, m_retry = 0;

    // Stimulus controls
    bit frames_on   = 1'b1;
    bit force_fd    = 1'b0;
    bit err_with_fd = 1'b0;
    int gap         = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_left = 0; m_wf = 0; m_we = 0; m_since = 0;
        m_err = 0; m_frm = 0; m_last = 0; m_retry = 0;
    endtask

    task automatic model_step();
        int e;
        int f;
        e = int'(i_check_error);
        f = int'(i_frame_done);
        if (i_stop) begin
            m_state = S_IDLE;
            return;
        end
        case (m_state)
            S_IDLE, S_FAIL: begin
                if (i_start) begin
                    m_err = 0; m_frm = 0; m_last = 0; m_retry = 0;
                    m_state = S_RESET; m_left = TB_RST;
                end
            end
            S_RESET: begin
                m_left--;
                if (m_left == 0) begin m_state = S_SETTLE; m_left = TB_SETTLE; end
            end
            S_SETTLE: begin
                if (i_2711_los) m_state = S_RETRY;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = S_CHECK; m_wf = 0; m_we = 0; m_since = 0;
                    end
                end
            end
            S_CHECK, S_LINKED: begin
                if (e == 1) begin
                    if (m_err < CMAX) m_err++;
                    m_last = int'(i_error_status);
                end
                if (f == 1 && m_frm < CMAX) m_frm++;
                if (m_we + e >= TB_THR || i_2711_los || m_since >= TB_TO) begin
                    m_state = S_RETRY;
                end else begin
                    if (m_wf + f == TB_WIN) begin
                        m_state = S_LINKED; m_wf = 0; m_we = 0;
                    end else begin
                        m_wf += f; m_we += e;
                    end
                    m_since = (f == 1) ? 0 : m_since + 1;
                end
            end
            S_RETRY: begin
                if (m_retry < 255) m_retry++;
                if (m_retry == TB_MAXR) m_state = S_FAIL;
                else begin m_state = S_RESET; m_left = TB_RST; end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state",     o_state,           m_state);
        check("soft_rst",  o_soft_rst,        m_state == S_RESET);
        check("check_ena", o_check_ena,
              m_state == S_SETTLE || m_state == S_CHECK || m_state == S_LINKED);
        check("link_up",   o_link_up,         m_state == S_LINKED);
        check("fail",      o_fail,            m_state == S_FAIL);
        check("err_cnt",   o_err_cnt,         m_err);
        check("frame_cnt", o_frame_cnt,       m_frm);
        check("last_err",  o_last_err_status, m_last);
        check("retry_cnt", o_retry_cnt,       m_retry);
    endtask

    // One clock cycle: finish driving this cycle's inputs, advance the model
    // at the edge, compare 1 time unit later, then drop single-cycle pulses.
    task automatic cyc();
        if (force_fd || (frames_on && gap == 0)) begin
            i_frame_done = 1'b1;
            gap = $urandom_range(FD_LO, FD_HI);
        end else begin
            i_frame_done = 1'b0;
            if (gap > 0) gap--;
        end
        if (err_with_fd && i_frame_done) begin
            i_check_error  = 1'b1;
            i_error_status = 4'($urandom_range(1, 10));
        end
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        i_start = 1'b0; i_stop = 1'b0; i_check_error = 1'b0; force_fd = 1'b0;
    endtask

    task automatic wait_state(input int s, input int bound, input string name);
        int k;
        k = 0;
        while (int'(o_state) != s && k < bound) begin
            cyc();
            k++;
        end
        check(name, o_state, s);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;

        // Reset state
        #12;
        model_reset();
        compare_all();
        check("reset_state_lit", o_state, 0);
        #10 rst_n = 1'b1;

        // Clean link with errors during SETTLE that must be ignored
        sc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) i_start = 1'b1;
            if (i >= 20 && (i % 2) == 0) begin
                i_check_error = 1'b1; i_error_status = 4'd1;
            end
            cyc();
            sc += int'(o_soft_rst);
        end
        check("soft_rst_width", sc, 16);
        check("settle_err_ignored", o_err_cnt, 0);
        check("in_settle", o_state, 2);
        wait_state(S_CHECK, 100, "reach_check");
        wait_state(S_LINKED, 200, "reach_linked");
        check("frames_at_linked", o_frame_cnt, 8);

        // Error and frame in the same cycle: both counted
        i_check_error = 1'b1; i_error_status = 4'd3; force_fd = 1'b1;
        cyc();
        check("same_cycle_err", o_err_cnt, 1);
        check("same_cycle_frm", o_frame_cnt, 9);

        // Long clean run saturates the frame counter
        for (int i = 0; i < 700; i++) cyc();
        check("frame_saturated", o_frame_cnt, 63);
        check("still_linked", o_link_up, 1);

        // LOS in LINKED: link_up drops on the next cycle
        i_2711_los = 1'b1;
        cyc();
        i_2711_los = 1'b0;
        check("los_link_drop", o_link_up, 0);
        check("los_retry", o_state, 5);

        // Frame timeout in LINKED
        wait_state(S_LINKED, 400, "relink");
        frames_on = 1'b0;
        wait_state(S_RETRY, 400, "timeout_retry");
        frames_on = 1'b1;

        // Bad window from a fresh start
        i_stop = 1'b1; cyc();
        i_start = 1'b1; cyc();
        wait_state(S_CHECK, 200, "bw_check");
        for (int i = 0; i < 4; i++) begin
            i_check_error = 1'b1; i_error_status = 4'd8;
            cyc();
            if (i < 3) begin cyc(); cyc(); end
        end
        check("bw_retry_state", o_state, 5);
        sc = 0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            if (i == 0) begin
                check("bw_retry_cnt", o_retry_cnt, 1);
                check("bw_last_status", o_last_err_status, 8);
            end
            sc += int'(o_soft_rst);
        end
        check("bw_soft_rst_width", sc, 16);

        // Persistent errors: exhaust retries
        i_stop = 1'b1; cyc();
        i_start = 1'b1; cyc();
        err_with_fd = 1'b1;
        wait_state(S_FAIL, 3000, "reach_fail");
        err_with_fd = 1'b0;
        check("fail_flag", o_fail, 1);
        check("fail_retries", o_retry_cnt, 8);
        check("fail_ena", o_check_ena, 0);

        // Start and stop together in FAIL: stop wins
        i_start = 1'b1; i_stop = 1'b1;
        cyc();
        check("stop_wins", o_state, 0);
        i_start = 1'b1;
        cyc();
        check("restart_state", o_state, 1);
        check("restart_err", o_err_cnt, 0);
        check("restart_frm", o_frame_cnt, 0);
        check("restart_retry", o_retry_cnt, 0);

        // Randomised operation
        for (int i = 0; i < 3000; i++) begin
            i_start        = ($urandom_range(0, 199) == 0);
            i_stop         = ($urandom_range(0, 499) == 0);
            i_2711_los     = ($urandom_range(0, 399) == 0);
            i_check_error  = ($urandom_range(0, 19) == 0);
            i_error_status = 4'($urandom_range(1, 10));
            cyc();
        end
        i_2711_los = 1'b0;

        // Asynchronous reset in CHECK
        i_stop = 1'b1; cyc();
        i_start = 1'b1; cyc();
        wait_state(S_CHECK, 200, "ar_check");
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_soft_rst", o_soft_rst, 0);
        check("ar_check_ena", o_check_ena, 0);
        check("ar_state", o_state, 0);
        check("ar_frame_cnt", o_frame_cnt, 0);
        compare_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        i_start = 1'b1;
        for (int i = 0; i < 30; i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
